// File: rtl/l2_if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l2_if_pkg
// Description : Shared definitions for the L1-to-L2 request path: command
//               encodings, default line-address width, queue entry layout,
//               output-stage state encoding and a command legality helper.
// Revision    : 1.0 - initial release
// ============================================================================
package l2_if_pkg;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    localparam int L2_ADDR_W = 26;

    typedef struct packed {
        logic [1:0]           cmd;
        logic [L2_ADDR_W-1:0] addr;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FULL   = 2'd2
    } oq_state_e;

    function automatic logic cmd_is_legal(input logic [1:0] cmd);
        return (cmd == CMD_READ) || (cmd == CMD_WRITE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/l2_request_queue_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock show-ahead FIFO. The head entry is visible
//               combinationally whenever the FIFO is non-empty; the most
//               recently written (tail) entry is also exposed so the caller
//               can inspect it before deciding whether to push.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               push, push_data - write one entry at the tail
//               pop             - discard the head entry
//               head_data       - current head entry
//               tail_data       - current tail entry (valid when !empty)
//               count           - occupancy, 0..DEPTH
//               full, empty     - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 28
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [WIDTH-1:0]         tail_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    // Storage carries no reset; occupancy alone decides what is meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_data = r_mem[r_rd_ptr];
    assign tail_data = r_mem[r_wr_ptr - c_PTR_W'(1)];
    assign count     = r_count;
    assign full      = (r_count == c_CNT_W'(DEPTH));
    assign empty     = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/l2_request_queue.sv
`default_nettype none
// ============================================================================
// Module      : l2_request_queue
// Description : In-order request queue between the L1 data cache and the L2.
//               Accepts read/write line requests, folds a write into an
//               identical write already sitting at the tail, presents the
//               head to the L2 over valid/ready and keeps forwarding stats.
// Ports       : clk, rst               - clock, synchronous active-high reset
//               req_valid/cmd_in/add_in - L1 request (cmd 01 read, 10 write)
//               req_ready               - queue can take a request
//               l2_valid/l2_cmd/l2_addr - head entry offered to the L2
//               l2_ready                - L2 takes the head this cycle
//               stat_clear              - zero the statistics counters
//               fwd_reads, fwd_writes   - entries delivered, by command
//               merged_writes           - writes folded into the tail
//               stall_cycles            - cycles offered but not taken
// Revision    : 1.0 - initial release
// ============================================================================
module l2_request_queue
    import l2_if_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = L2_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [1:0]        cmd_in,
    input  logic [ADDR_W-1:0] add_in,
    output logic              req_ready,
    output logic              l2_valid,
    output logic [1:0]        l2_cmd,
    output logic [ADDR_W-1:0] l2_addr,
    input  logic              l2_ready,
    input  logic              stat_clear,
    output logic [31:0]       fwd_reads,
    output logic [31:0]       fwd_writes,
    output logic [31:0]       merged_writes,
    output logic [31:0]       stall_cycles
);

    localparam int c_ENTRY_W = ADDR_W + 2;
    localparam int c_CNT_W   = $clog2(DEPTH) + 1;

    logic [c_ENTRY_W-1:0] w_fifo_head;
    logic [c_ENTRY_W-1:0] w_fifo_tail;
    logic [c_CNT_W-1:0]   w_fifo_count;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;

    logic [1:0]           w_head_cmd;
    logic [ADDR_W-1:0]    w_head_addr;
    logic [1:0]           w_tail_cmd;
    logic [ADDR_W-1:0]    w_tail_addr;

    logic                 w_accept;
    logic                 w_merge;
    logic                 w_push;
    logic                 w_pop;

    oq_state_e            r_state;
    oq_state_e            w_state_nxt;

    logic [31:0]          r_fwd_reads;
    logic [31:0]          r_fwd_writes;
    logic [31:0]          r_merged_writes;
    logic [31:0]          r_stall_cycles;

    // Entry layout: {cmd, addr}
    assign w_head_cmd  = w_fifo_head[c_ENTRY_W-1 -: 2];
    assign w_head_addr = w_fifo_head[ADDR_W-1:0];
    assign w_tail_cmd  = w_fifo_tail[c_ENTRY_W-1 -: 2];
    assign w_tail_addr = w_fifo_tail[ADDR_W-1:0];

    // Handshake flags come straight from registered state so neither side
    // sees a combinational path from the other.
    assign req_ready = (r_state != ST_FULL);
    assign l2_valid  = (r_state != ST_EMPTY);

    // Outputs read as zero while nothing is offered, so stale storage never
    // shows up on the L2 bus.
    assign l2_cmd  = l2_valid ? w_head_cmd  : CMD_NONE;
    assign l2_addr = l2_valid ? w_head_addr : '0;

    assign w_pop    = l2_valid && l2_ready && !w_fifo_empty;
    assign w_accept = req_valid && req_ready && cmd_is_legal(cmd_in);

    // Fold only into a tail that survives this cycle: a lone entry that is
    // leaving now has already been committed to the L2.
    assign w_merge = w_accept
                  && (cmd_in == CMD_WRITE)
                  && !w_fifo_empty
                  && (w_tail_cmd == CMD_WRITE)
                  && (w_tail_addr == add_in)
                  && ((w_fifo_count > c_CNT_W'(1)) || !w_pop);

    assign w_push = w_accept && !w_merge && !w_fifo_full;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data ({cmd_in, add_in}),
        .pop       (w_pop),
        .head_data (w_fifo_head),
        .tail_data (w_fifo_tail),
        .count     (w_fifo_count),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (w_push && !w_pop && (w_fifo_count == c_CNT_W'(DEPTH - 1))) begin
                    w_state_nxt = ST_FULL;
                end else if (w_pop && !w_push && (w_fifo_count == c_CNT_W'(1))) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_pop) begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || stat_clear) begin
            r_fwd_reads     <= '0;
            r_fwd_writes    <= '0;
            r_merged_writes <= '0;
            r_stall_cycles  <= '0;
        end else begin
            if (w_pop && (w_head_cmd == CMD_READ)) begin
                r_fwd_reads <= r_fwd_reads + 32'd1;
            end
            if (w_pop && (w_head_cmd == CMD_WRITE)) begin
                r_fwd_writes <= r_fwd_writes + 32'd1;
            end
            if (w_merge) begin
                r_merged_writes <= r_merged_writes + 32'd1;
            end
            if (l2_valid && !l2_ready) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign fwd_reads     = r_fwd_reads;
    assign fwd_writes    = r_fwd_writes;
    assign merged_writes = r_merged_writes;
    assign stall_cycles  = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_l2_request_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_request_queue
// Description : Self-checking bench for l2_request_queue. A queue-based
//               reference model tracks the expected contents and counters;
//               directed scenarios pin known values, then random traffic
//               exercises merging, backpressure, clears and resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_request_queue;
    import l2_if_pkg::*;

    localparam int c_DEPTH  = 8;
    localparam int c_ADDR_W = 26;

    logic                clk;
    logic                rst;
    logic                req_valid;
    logic [1:0]          cmd_in;
    logic [c_ADDR_W-1:0] add_in;
    logic                req_ready;
    logic                l2_valid;
    logic [1:0]          l2_cmd;
    logic [c_ADDR_W-1:0] l2_addr;
    logic                l2_ready;
    logic                stat_clear;
    logic [31:0]         fwd_reads;
    logic [31:0]         fwd_writes;
    logic [31:0]         merged_writes;
    logic [31:0]         stall_cycles;

    int n_tests;
    int n_fail;
    bit chk_en;

    // Reference model state
    entry_t      m_q[$];
    logic [31:0] m_fr, m_fw, m_mw, m_st;

    l2_request_queue #(
        .DEPTH  (c_DEPTH),
        .ADDR_W (c_ADDR_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .cmd_in        (cmd_in),
        .add_in        (add_in),
        .req_ready     (req_ready),
        .l2_valid      (l2_valid),
        .l2_cmd        (l2_cmd),
        .l2_addr       (l2_addr),
        .l2_ready      (l2_ready),
        .stat_clear    (stat_clear),
        .fwd_reads     (fwd_reads),
        .fwd_writes    (fwd_writes),
        .merged_writes (merged_writes),
        .stall_cycles  (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what the queue and counters must look like after each edge.
    always @(posedge clk) begin
        int sz;
        bit pop, acc, mrg, stall;
        sz = m_q.size();
        if (rst) begin
            m_q.delete();
            m_fr = 0; m_fw = 0; m_mw = 0; m_st = 0;
        end else begin
            pop   = (sz != 0) && l2_ready;
            acc   = req_valid && (sz < c_DEPTH) && (cmd_in == 2'b01 || cmd_in == 2'b10);
            mrg   = acc && (cmd_in == 2'b10) && (sz != 0)
                 && (m_q[sz-1].cmd == 2'b10) && (m_q[sz-1].addr == add_in)
                 && !(sz == 1 && pop);
            stall = (sz != 0) && !l2_ready;
            if (stat_clear) begin
                m_fr = 0; m_fw = 0; m_mw = 0; m_st = 0;
            end else begin
                if (pop && m_q[0].cmd == 2'b01) m_fr = m_fr + 1;
                if (pop && m_q[0].cmd == 2'b10) m_fw = m_fw + 1;
                if (mrg)   m_mw = m_mw + 1;
                if (stall) m_st = m_st + 1;
            end
            if (pop) void'(m_q.pop_front());
            if (acc && !mrg) m_q.push_back('{cmd: cmd_in, addr: add_in});
        end
    end

    // Compare DUT to model every cycle, midway between active edges.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", {31'd0, req_ready}, {31'd0, m_q.size() != c_DEPTH});
            chk("l2_valid",  {31'd0, l2_valid},  {31'd0, m_q.size() != 0});
            chk("l2_cmd",    {30'd0, l2_cmd},    (m_q.size() != 0) ? {30'd0, m_q[0].cmd} : 32'd0);
            chk("l2_addr",   {6'd0, l2_addr},    (m_q.size() != 0) ? {6'd0, m_q[0].addr} : 32'd0);
            chk("fwd_reads",     fwd_reads,     m_fr);
            chk("fwd_writes",    fwd_writes,    m_fw);
            chk("merged_writes", merged_writes, m_mw);
            chk("stall_cycles",  stall_cycles,  m_st);
        end
    end

    // Apply inputs now (just after a falling edge) and wait one full cycle.
    task automatic tick(input bit v, input logic [1:0] c, input logic [c_ADDR_W-1:0] a, input bit r);
        req_valid = v;
        cmd_in    = c;
        add_in    = a;
        l2_ready  = r;
        @(negedge clk);
    endtask

    task automatic clr();
        stat_clear = 1'b1;
        tick(1'b0, 2'b00, '0, 1'b0);
        stat_clear = 1'b0;
    endtask

    initial begin
        int rdy_pct;
        n_tests = 0; n_fail = 0; chk_en = 1'b0;
        rst = 1'b1; stat_clear = 1'b0;
        req_valid = 1'b0; cmd_in = 2'b00; add_in = '0; l2_ready = 1'b0;
        @(negedge clk);
        tick(1'b0, 2'b00, '0, 1'b0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state
        chk("rst_l2_valid",  {31'd0, l2_valid}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_l2_cmd",    {30'd0, l2_cmd}, 32'd0);
        chk("rst_l2_addr",   {6'd0, l2_addr}, 32'd0);
        chk("rst_fwd_reads", fwd_reads, 32'd0);

        // Single read, one cycle latency
        tick(1'b1, 2'b01, 26'h0ABCDEF, 1'b1);
        chk("rd_l2_valid", {31'd0, l2_valid}, 32'd1);
        chk("rd_l2_cmd",   {30'd0, l2_cmd}, 32'd1);
        chk("rd_l2_addr",  {6'd0, l2_addr}, 32'h0ABCDEF);
        tick(1'b0, 2'b00, '0, 1'b1);
        chk("rd_fwd_reads", fwd_reads, 32'd1);
        chk("rd_req_ready", {31'd0, req_ready}, 32'd1);

        // Merge of back-to-back writes, read not merged
        clr();
        repeat (3) tick(1'b1, 2'b10, 26'h100, 1'b0);
        chk("mg_merged", merged_writes, 32'd2);
        tick(1'b1, 2'b01, 26'h100, 1'b0);
        chk("mg_head_cmd", {30'd0, l2_cmd}, 32'd2);
        tick(1'b0, 2'b00, '0, 1'b1);
        chk("mg_fwd_writes", fwd_writes, 32'd1);
        chk("mg_second_cmd", {30'd0, l2_cmd}, 32'd1);
        chk("mg_second_addr", {6'd0, l2_addr}, 32'h100);
        tick(1'b0, 2'b00, '0, 1'b1);
        chk("mg_fwd_reads", fwd_reads, 32'd1);
        chk("mg_drained", {31'd0, l2_valid}, 32'd0);

        // Full and backpressure
        clr();
        for (int i = 0; i < 8; i++) tick(1'b1, 2'b01, c_ADDR_W'(i), 1'b0);
        chk("full_req_ready", {31'd0, req_ready}, 32'd0);
        tick(1'b1, 2'b01, 26'h8, 1'b0);
        chk("full_head_addr", {6'd0, l2_addr}, 32'd0);
        chk("full_stalls", stall_cycles, 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("drain_addr", {6'd0, l2_addr}, i);
            tick(1'b0, 2'b00, '0, 1'b1);
        end
        chk("drain_fwd_reads", fwd_reads, 32'd8);
        chk("drain_empty", {31'd0, l2_valid}, 32'd0);

        // Push and pop with a single write at head: no merge
        clr();
        tick(1'b1, 2'b10, 26'h200, 1'b0);
        tick(1'b1, 2'b10, 26'h200, 1'b1);
        chk("pp_merged", merged_writes, 32'd0);
        chk("pp_valid", {31'd0, l2_valid}, 32'd1);
        chk("pp_addr", {6'd0, l2_addr}, 32'h200);
        tick(1'b0, 2'b00, '0, 1'b1);
        chk("pp_fwd_writes", fwd_writes, 32'd2);

        // Reset mid-operation, with simultaneous push and pop requested
        for (int i = 1; i <= 3; i++) tick(1'b1, 2'b01, c_ADDR_W'(i), 1'b0);
        chk("mr_valid_before", {31'd0, l2_valid}, 32'd1);
        rst = 1'b1;
        tick(1'b1, 2'b01, 26'h9, 1'b1);
        rst = 1'b0;
        chk("mr_valid", {31'd0, l2_valid}, 32'd0);
        chk("mr_stalls", stall_cycles, 32'd0);
        chk("mr_fwd_reads", fwd_reads, 32'd0);

        // Stat clear with simultaneous pop, then illegal commands
        tick(1'b1, 2'b01, 26'h11, 1'b0);
        tick(1'b1, 2'b10, 26'h22, 1'b0);
        tick(1'b1, 2'b01, 26'h33, 1'b0);
        tick(1'b0, 2'b00, '0, 1'b1);
        chk("sc_fwd_reads_pre", fwd_reads, 32'd1);
        stat_clear = 1'b1;
        tick(1'b0, 2'b00, '0, 1'b1);
        stat_clear = 1'b0;
        chk("sc_fwd_writes", fwd_writes, 32'd0);
        chk("sc_stalls", stall_cycles, 32'd0);
        chk("sc_head_addr", {6'd0, l2_addr}, 32'h33);
        tick(1'b1, 2'b00, 26'h44, 1'b0);
        tick(1'b1, 2'b11, 26'h55, 1'b0);
        chk("il_head_addr", {6'd0, l2_addr}, 32'h33);
        tick(1'b0, 2'b00, '0, 1'b1);
        chk("il_empty", {31'd0, l2_valid}, 32'd0);
        chk("il_fwd_reads", fwd_reads, 32'd1);

        // Random traffic over a small address set to provoke merges
        rdy_pct = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0:       rdy_pct = 15;
                    1:       rdy_pct = 50;
                    default: rdy_pct = 90;
                endcase
            end
            rst        = ($urandom_range(0, 299) == 0);
            stat_clear = ($urandom_range(0, 59) == 0);
            tick($urandom_range(0, 3) != 0,
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) == 0) ? c_ADDR_W'($urandom) : c_ADDR_W'($urandom_range(0, 3)),
                 $urandom_range(0, 99) < rdy_pct);
        end
        rst = 1'b0;
        stat_clear = 1'b0;
        tick(1'b0, 2'b00, '0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
